// File: rtl/sw9_sched_pkg.sv
// Shared definitions for the child round-robin scheduler: FSM states,
// default sizing and the grant index type.
package sw9_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } sched_state_t;

    localparam int N_REQ_DEFAULT    = 5;
    localparam int MAX_HOLD_DEFAULT = 16;
    localparam int ID_W_DEFAULT     = 3;

    typedef logic [ID_W_DEFAULT-1:0] gnt_idx_t;

endpackage

// File: rtl/sw9_rr_pick.sv
// Circular first-set-bit search over the eligible vector, starting one
// position after the previous winner.
module sw9_rr_pick
    import sw9_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    localparam int unsigned NR = N_REQ;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NR) s = s - NR;
        return ID_W'(s);
    endfunction

    // Offsets 1..N_REQ visit last+1 first and the previous winner last.
    always_comb begin
        winner = last;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            if (!found && elig[wrap_idx(last, i)]) begin
                winner = wrap_idx(last, i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw9_child_rr_scheduler.sv
// Round-robin slot scheduler for five leaf children with a mandatory gap
// cycle between grants and a hold-time watchdog.
module sw9_child_rr_scheduler
    import sw9_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int ID_W     = ID_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    input  logic [N_REQ-1:0] en_mask,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout,
    output logic [4:0]       hold_cnt
);

    localparam logic [4:0]       HOLD_MAX = 5'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    sched_state_t     state, state_n;
    logic [ID_W-1:0]  last, last_n, gnt_id_n, winner;
    logic [N_REQ-1:0] elig, gnt_n;
    logic [4:0]       hold_n;
    logic             timeout_n, found;
    logic             end_mask, end_rel, end_req, end_age;

    assign elig      = req & en_mask;
    assign gnt_valid = |gnt;

    assign end_mask = !en_mask[gnt_id];
    assign end_rel  = rel[gnt_id];
    assign end_req  = !req[gnt_id];
    assign end_age  = (hold_cnt == HOLD_MAX);

    sw9_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .elig   (elig),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        last_n    = last;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            GRANT: begin
                if (end_mask || end_rel || end_req || end_age) begin
                    state_n   = GAP;
                    gnt_n     = '0;
                    hold_n    = '0;
                    // Watchdog pulse only when no higher-priority end cause applies.
                    timeout_n = !end_mask && !end_rel && !end_req;
                end else begin
                    hold_n = hold_cnt + 5'd1;
                end
            end
            IDLE, GAP: begin
                if (found) begin
                    state_n  = GRANT;
                    gnt_n    = ONE << winner;
                    gnt_id_n = winner;
                    last_n   = winner;
                    hold_n   = 5'd1;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    hold_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last     <= LAST_RST;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            last     <= last_n;
            timeout  <= timeout_n;
            hold_cnt <= hold_n;
        end
    end

endmodule

// File: tb/tb_sw9_child_rr_scheduler.sv
// Self-checking bench for sw9_child_rr_scheduler: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_sw9_child_rr_scheduler;

    localparam int N    = 5;
    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req, rel, en_mask;
    logic [4:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       timeout;
    logic [4:0] hold_cnt;

    always #5 clk = ~clk;

    sw9_child_rr_scheduler #(
        .N_REQ    (N),
        .MAX_HOLD (MAXH),
        .ID_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .en_mask   (en_mask),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout),
        .hold_cnt  (hold_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit seen_g1 = 1'b0;

    // Reference model: who holds the slot, for how long, and the last winner.
    bit m_busy = 1'b0;
    int m_id   = 0;
    int m_last = N - 1;
    int m_age  = 0;
    bit m_to   = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_edge();
        int pick;
        m_to = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_id   = 0;
            m_last = N - 1;
            m_age  = 0;
        end else if (m_busy) begin
            if (!en_mask[m_id] || rel[m_id] || !req[m_id]) begin
                m_busy = 1'b0;
                m_age  = 0;
            end else if (m_age == MAXH) begin
                m_busy = 1'b0;
                m_age  = 0;
                m_to   = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (pick < 0 && req[c] && en_mask[c]) pick = c;
            end
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_id   = pick;
                m_last = pick;
                m_age  = 1;
            end
        end
    endfunction

    task automatic step();
        logic [4:0] exp_gnt;
        model_edge();
        @(posedge clk);
        #1;
        exp_gnt = m_busy ? 5'(1 << m_id) : 5'd0;
        chk("gnt", gnt, exp_gnt);
        chk("gnt_id", gnt_id, m_id);
        chk("gnt_valid", gnt_valid, m_busy);
        chk("timeout", timeout, m_to);
        chk("hold_cnt", hold_cnt, m_busy ? m_age : 0);
        chk("gnt_onehot", gnt & (gnt - 5'd1), 0);
        if (gnt[1]) seen_g1 = 1'b1;
    endtask

    task automatic wait_grant();
        int b;
        b = 0;
        while (gnt == 5'd0 && b < 10) begin
            step();
            b++;
        end
        chk("wait_grant", gnt_valid, 1);
    endtask

    typedef struct {
        bit         rst;
        logic [4:0] req;
        logic [4:0] rel;
        logic [4:0] en;
        logic [4:0] gnt;
        logic [2:0] id;
        bit         to;
        logic [4:0] hold;
    } vec_t;

    vec_t tbl[15];
    int   order_rot[6];
    int   zeros, high, b;

    initial begin
        tbl[0]  = '{1'b1, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 3'd0, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 5'b10100, 5'b00000, 5'b11111, 5'b00100, 3'd2, 1'b0, 5'd1};
        tbl[2]  = '{1'b0, 5'b10100, 5'b00000, 5'b11111, 5'b00100, 3'd2, 1'b0, 5'd2};
        tbl[3]  = '{1'b0, 5'b10100, 5'b00001, 5'b11111, 5'b00100, 3'd2, 1'b0, 5'd3};
        tbl[4]  = '{1'b0, 5'b10100, 5'b00100, 5'b11111, 5'b00000, 3'd2, 1'b0, 5'd0};
        tbl[5]  = '{1'b0, 5'b10100, 5'b00000, 5'b11111, 5'b10000, 3'd4, 1'b0, 5'd1};
        tbl[6]  = '{1'b0, 5'b10100, 5'b00000, 5'b01111, 5'b00000, 3'd4, 1'b0, 5'd0};
        tbl[7]  = '{1'b0, 5'b10100, 5'b00000, 5'b01111, 5'b00100, 3'd2, 1'b0, 5'd1};
        tbl[8]  = '{1'b0, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 3'd2, 1'b0, 5'd0};
        tbl[9]  = '{1'b0, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 3'd2, 1'b0, 5'd0};
        tbl[10] = '{1'b0, 5'b00010, 5'b00000, 5'b11111, 5'b00010, 3'd1, 1'b0, 5'd1};
        tbl[11] = '{1'b1, 5'b00010, 5'b00000, 5'b11111, 5'b00000, 3'd0, 1'b0, 5'd0};
        tbl[12] = '{1'b0, 5'b11111, 5'b00000, 5'b11111, 5'b00001, 3'd0, 1'b0, 5'd1};
        tbl[13] = '{1'b0, 5'b11111, 5'b00001, 5'b11111, 5'b00000, 3'd0, 1'b0, 5'd0};
        tbl[14] = '{1'b0, 5'b11111, 5'b00000, 5'b11111, 5'b00010, 3'd1, 1'b0, 5'd1};
        order_rot = '{0, 1, 2, 3, 4, 0};

        rst = 1'b1; req = '0; rel = '0; en_mask = '1;

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; rel = tbl[i].rel; en_mask = tbl[i].en;
            step();
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("vec%0d_id", i), gnt_id, tbl[i].id);
            chk($sformatf("vec%0d_to", i), timeout, tbl[i].to);
            chk($sformatf("vec%0d_hold", i), hold_cnt, tbl[i].hold);
        end

        // Release rotation with exactly one empty cycle between grants.
        rst = 1'b1; req = '0; rel = '0; en_mask = '1;
        step();
        rst = 1'b0; req = 5'b11111;
        zeros = 0;
        for (int g = 0; g < 6; g++) begin
            b = 0;
            while (gnt == 5'd0 && b < 10) begin
                step();
                b++;
                if (gnt == 5'd0) zeros++;
            end
            chk("rot_wait", gnt_valid, 1);
            chk("rot_order", gnt_id, order_rot[g]);
            if (g > 0) chk("rot_gap", zeros, 1);
            rel = gnt;
            step();
            rel = '0;
            zeros = (gnt == 5'd0) ? 1 : 0;
        end

        // Watchdog revoke, gap, then re-grant to the sole requester.
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0; req = 5'b00001;
        step();
        chk("wd_start", gnt, 5'b00001);
        high = 1;
        while (gnt != 5'd0 && high < 40) begin
            step();
            if (gnt != 5'd0) begin
                high++;
                chk("wd_no_early_to", timeout, 0);
            end
        end
        chk("wd_len", high, MAXH);
        chk("wd_timeout", timeout, 1);
        step();
        chk("wd_regrant", gnt, 5'b00001);
        chk("wd_regrant_hold", hold_cnt, 1);
        chk("wd_to_single", timeout, 0);

        // Release arriving on the watchdog cycle counts as a release.
        b = 0;
        while (hold_cnt != 5'd16 && b < 30) begin
            step();
            b++;
        end
        chk("relmax_reach", hold_cnt, 16);
        rel = 5'b00001;
        step();
        rel = '0;
        chk("relmax_to", timeout, 0);
        chk("relmax_gnt", gnt, 0);

        // Masked child skipped; clearing a holder's enable drops without timeout.
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0; req = 5'b11111; en_mask = 5'b11111;
        step();
        chk("mask_first", gnt_id, 0);
        en_mask = 5'b11101;
        seen_g1 = 1'b0;
        rel = gnt; step(); rel = '0;
        wait_grant();
        chk("mask_order_2", gnt_id, 2);
        en_mask = 5'b11001;
        step();
        chk("mask_drop_gnt", gnt, 0);
        chk("mask_drop_to", timeout, 0);
        en_mask = 5'b11101;
        wait_grant();
        chk("mask_order_3", gnt_id, 3);
        rel = gnt; step(); rel = '0;
        wait_grant();
        chk("mask_order_4", gnt_id, 4);
        rel = gnt; step(); rel = '0;
        wait_grant();
        chk("mask_order_0", gnt_id, 0);
        chk("mask_child1_never", seen_g1, 0);

        // Randomized traffic against the reference model.
        rst = 1'b1; req = '0; rel = '0; en_mask = '1;
        step();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) req = 5'($urandom);
            rel = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            if ($urandom_range(0, 15) == 0)
                en_mask = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'b11111;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
